// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited reads into a pipelined instruction memory,
// returns buffered in a circular queue and delivered to the next stage under backpressure.
package ifetch_pkg;
  typedef struct packed {
    logic        v;
    logic [31:0] data;
  } instr_t;
endpackage

module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Req,
  input  logic                       I_Term,
  input  logic                       I_Flush,
  input  logic                       I_Empty,
  input  instr_t                     I_Instr,
  input  logic                       I_Stall,
  output logic                       O_Re_Instr,
  output logic                       O_Req,
  output instr_t                     O_Instr,
  output logic [$clog2(DEPTH+1)-1:0] O_Count,
  output logic                       O_Full,
  output logic                       O_Busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [MEM_LAT-1:0]   infl_q, infl_d, disc_q, disc_d;
  instr_t               mem_q [DEPTH];
  instr_t               mem_d [DEPTH];
  instr_t               last_q, last_d;

  logic [CW+1:0]        infl_cnt_s;
  logic                 credit_s, re_s, push_s, pop_s, ret_s;

  // Credit check counts discarded slots too, since they still occupy the memory pipe.
  always_comb begin
    infl_cnt_s = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      infl_cnt_s = infl_cnt_s + (CW+2)'(infl_q[i]);
    end
    credit_s = (({2'b00, count_q} + infl_cnt_s) < (CW+2)'(DEPTH));
    re_s     = (state_q == FETCH) && !I_Empty && !I_Term && !I_Flush && credit_s;
    ret_s    = infl_q[MEM_LAT-1] && !disc_q[MEM_LAT-1];
    push_s   = ret_s && I_Instr.v && !I_Flush;
    pop_s    = (count_q != '0) && !I_Stall && !I_Flush;
  end

  // Next-state computation for the FSM, queue and in-flight tracking.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    last_d   = last_q;
    infl_d   = '0;
    disc_d   = '0;

    infl_d[0] = re_s;
    disc_d[0] = 1'b0;
    for (int i = 1; i < MEM_LAT; i++) begin
      infl_d[i] = infl_q[i-1];
      disc_d[i] = disc_q[i-1] || I_Flush;
    end

    if (I_Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = I_Instr;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Remember the departing head so O_Instr stays defined once the queue empties.
    if ((pop_s || I_Flush) && (count_q != '0)) begin
      last_d = mem_q[rd_ptr_q];
    end else begin
      last_d = last_q;
    end

    case (state_q)
      IDLE: begin
        if (I_Req && !I_Term) state_d = FETCH;
        else                  state_d = IDLE;
      end
      FETCH: begin
        if (I_Term) state_d = DRAIN;
        else        state_d = FETCH;
      end
      DRAIN: begin
        if (I_Flush || ((count_q == '0) && (infl_cnt_s == '0))) state_d = IDLE;
        else                                                     state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops every in-flight read so stale returns are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      disc_q   <= '0;
      last_q   <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      disc_q   <= disc_d;
      last_q   <= last_d;
      mem_q    <= mem_d;
    end
  end

  assign O_Re_Instr = re_s;
  assign O_Req      = (count_q != '0);
  assign O_Instr    = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign O_Count    = count_q;
  assign O_Full     = (count_q == CW'(DEPTH));
  assign O_Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4, MEM_LAT=1); the bench acts as a
// one-cycle instruction memory returning 0x1000+n for the n-th read.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  logic       clock, reset;
  logic       I_Req, I_Term, I_Flush, I_Empty, I_Stall;
  instr_t     I_Instr;
  logic       O_Re_Instr, O_Req, O_Full, O_Busy;
  instr_t     O_Instr;
  logic [2:0] O_Count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  logic drop   = 1'b0;

  ifetch_queue #(.DEPTH(4), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .I_Req(I_Req), .I_Term(I_Term), .I_Flush(I_Flush), .I_Empty(I_Empty),
    .I_Instr(I_Instr), .I_Stall(I_Stall),
    .O_Re_Instr(O_Re_Instr), .O_Req(O_Req), .O_Instr(O_Instr),
    .O_Count(O_Count), .O_Full(O_Full), .O_Busy(O_Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic instr_t dat(input int i);
    instr_t t;
    t.v    = 1'b1;
    t.data = 32'h0000_1000 + i;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; memory answers a read seen in the cycle just ended.
  task automatic tick();
    logic re;
    #1;
    re = O_Re_Instr;
    @(posedge clock);
    #1;
    if (re) begin
      I_Instr   = dat(n_rd);
      I_Instr.v = ~drop;
      n_rd++;
    end else begin
      I_Instr = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    I_Req = 1'b0; I_Term = 1'b0; I_Flush = 1'b0; I_Empty = 1'b0; I_Stall = 1'b0;
    I_Instr = '0; drop = 1'b0; n_rd = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    I_Req = 1'b0; I_Term = 1'b0; I_Flush = 1'b0; I_Empty = 1'b0; I_Stall = 1'b0;
    I_Instr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_re",    O_Re_Instr, 0);
    chk("rst_req",   O_Req,      0);
    chk("rst_instr", O_Instr,    0);
    chk("rst_count", O_Count,    0);
    chk("rst_full",  O_Full,     0);
    chk("rst_busy",  O_Busy,     0);

    // Streaming
    do_reset();
    I_Req = 1'b1; tick(); I_Req = 1'b0; #1;
    chk("stream_re_c1", O_Re_Instr, 1);
    chk("stream_busy",  O_Busy,     1);
    tick(); chk("stream_noreq_c2", O_Req, 0);
    tick(); chk("stream_A", {O_Req, O_Instr}, {1'b1, dat(0)});
    tick(); chk("stream_B", {O_Req, O_Instr}, {1'b1, dat(1)});
    tick(); chk("stream_C", {O_Req, O_Instr}, {1'b1, dat(2)});

    // Backpressure
    do_reset();
    I_Stall = 1'b1; I_Req = 1'b1; tick(); I_Req = 1'b0;
    repeat (9) tick();
    chk("bp_count", O_Count,    4);
    chk("bp_full",  O_Full,     1);
    chk("bp_re",    O_Re_Instr, 0);
    chk("bp_head",  {O_Req, O_Instr}, {1'b1, dat(0)});
    I_Stall = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_deliver%0d", i), {O_Req, O_Instr}, {1'b1, dat(i)});
      tick();
    end

    // Termination with 3 queued and 1 in flight
    do_reset();
    I_Stall = 1'b1; I_Req = 1'b1; tick(); I_Req = 1'b0;
    repeat (4) tick();
    chk("term_pre_count", O_Count, 3);
    I_Term = 1'b1; tick(); I_Term = 1'b0; I_Stall = 1'b0; #1;
    chk("term_busy",  O_Busy,     1);
    chk("term_re",    O_Re_Instr, 0);
    chk("term_count", O_Count,    4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("term_deliver%0d", i), {O_Req, O_Instr}, {1'b1, dat(i)});
      tick();
    end
    chk("term_hold_last", {O_Req, O_Instr}, {1'b0, dat(3)});
    chk("term_busy_last", O_Busy, 1);
    tick();
    chk("term_idle", O_Busy, 0);

    // Flush with 2 queued and 1 in flight
    do_reset();
    I_Stall = 1'b1; I_Req = 1'b1; tick(); I_Req = 1'b0;
    repeat (3) tick();
    chk("flush_pre_count", O_Count, 2);
    I_Flush = 1'b1; #1;
    chk("flush_re", O_Re_Instr, 0);
    tick(); I_Flush = 1'b0; #1;
    chk("flush_count", O_Count, 0);
    chk("flush_req",   {O_Req, O_Instr}, {1'b0, dat(0)});
    chk("flush_busy",  O_Busy, 1);
    chk("flush_resume", O_Re_Instr, 1);
    tick(); chk("flush_dropped", O_Count, 0);
    tick(); chk("flush_D", {O_Req, O_Instr}, {1'b1, dat(3)});

    // Invalid return and memory empty
    do_reset();
    I_Stall = 1'b1; I_Req = 1'b1; tick(); I_Req = 1'b0;
    tick();
    drop = 1'b1; tick(); drop = 1'b0;
    tick();
    chk("inv_count", O_Count, 1);
    I_Empty = 1'b1; #1;
    chk("empty_re", O_Re_Instr, 0);
    tick();
    chk("inv_count2", O_Count, 2);
    I_Empty = 1'b0; I_Stall = 1'b0; #1;
    chk("inv_A", {O_Req, O_Instr}, {1'b1, dat(0)});
    tick();
    chk("inv_C", {O_Req, O_Instr}, {1'b1, dat(2)});

    // Async reset mid-stream, stale return, then I_Term priority in IDLE
    do_reset();
    I_Stall = 1'b1; I_Req = 1'b1; tick(); I_Req = 1'b0;
    repeat (4) tick();
    chk("ar_pre_count", O_Count, 3);
    #2; reset = 1'b0; #1;
    chk("ar_re",    O_Re_Instr, 0);
    chk("ar_req",   O_Req,      0);
    chk("ar_instr", O_Instr,    0);
    chk("ar_count", O_Count,    0);
    chk("ar_full",  O_Full,     0);
    chk("ar_busy",  O_Busy,     0);
    @(posedge clock); #1;
    I_Instr = dat(99); reset = 1'b1;
    @(posedge clock); #1;
    chk("ar_stale", O_Count, 0);
    I_Instr = '0;
    I_Req = 1'b1; I_Term = 1'b1; tick(); I_Req = 1'b0; I_Term = 1'b0; #1;
    chk("term_prio_idle", O_Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
